// File: rtl/cordic_hyp_core.sv
// Iterative hyperbolic CORDIC (rotation mode): cosh/sinh of a Q2.13 angle.
// Ports: clk, reset (async low), start, z_in -> busy, done, cosh_out, sinh_out, range_err.
// Optional input clamp with range flag: define CORDIC_HYP_RANGE_CHK_EN.
module cordic_hyp_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cosh_out,
  output logic [WIDTH-1:0] sinh_out,
  output logic             range_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic [3:0]              step_q, step_d;
  logic [WIDTH-1:0]        cosh_q, cosh_d;
  logic [WIDTH-1:0]        sinh_q, sinh_d;
  logic                    done_q, done_d;

  logic [3:0]              sh;
  logic signed [WIDTH-1:0] t_val;
  logic signed [WIDTH-1:0] xs, ys;
  logic signed [WIDTH-1:0] z_load;
  logic signed [WIDTH-1:0] z_s;

  assign z_s = z_in;

`ifdef CORDIC_HYP_RANGE_CHK_EN
  logic flag_q, flag_d;
  logic rerr_q, rerr_d;
  logic oor;

  always_comb begin
    z_load = z_s;
    oor    = 1'b0;
    unique case (1'b1)
      (z_s > WIDTH'(9160)): begin
        z_load = WIDTH'(9160);
        oor    = 1'b1;
      end
      (z_s < -WIDTH'(9160)): begin
        z_load = -WIDTH'(9160);
        oor    = 1'b1;
      end
      default: ;
    endcase
  end

  assign range_err = rerr_q;
`else
  assign z_load    = z_s;
  assign range_err = 1'b0;
`endif

  // Shift schedule; iterations 4 and 13 are repeated.
  always_comb begin
    unique case (step_q)
      4'd0, 4'd1, 4'd2, 4'd3: sh = step_q + 4'd1;
      4'd14, 4'd15:           sh = step_q - 4'd1;
      default:                sh = step_q;
    endcase
  end

  // atanh(2^-i) in Q2.13
  always_comb begin
    unique case (sh)
      4'd1:    t_val = WIDTH'(4500);
      4'd2:    t_val = WIDTH'(2092);
      4'd3:    t_val = WIDTH'(1029);
      4'd4:    t_val = WIDTH'(513);
      4'd5:    t_val = WIDTH'(256);
      4'd6:    t_val = WIDTH'(128);
      4'd7:    t_val = WIDTH'(64);
      4'd8:    t_val = WIDTH'(32);
      4'd9:    t_val = WIDTH'(16);
      4'd10:   t_val = WIDTH'(8);
      4'd11:   t_val = WIDTH'(4);
      4'd12:   t_val = WIDTH'(2);
      4'd13:   t_val = WIDTH'(1);
      4'd14:   t_val = WIDTH'(1);
      default: t_val = '0;
    endcase
  end

  assign xs = x_q >>> sh;
  assign ys = y_q >>> sh;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    step_d  = step_q;
    cosh_d  = cosh_q;
    sinh_d  = sinh_q;
    done_d  = 1'b0;
`ifdef CORDIC_HYP_RANGE_CHK_EN
    flag_d  = flag_q;
    rerr_d  = rerr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = WIDTH'(9892);
          y_d     = '0;
          z_d     = z_load;
          step_d  = '0;
`ifdef CORDIC_HYP_RANGE_CHK_EN
          flag_d  = oor;
`endif
        end
      end
      RUN: begin
        if (!z_q[WIDTH-1]) begin
          x_d = x_q + ys;
          y_d = y_q + xs;
          z_d = z_q - t_val;
        end else begin
          x_d = x_q - ys;
          y_d = y_q - xs;
          z_d = z_q + t_val;
        end
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        cosh_d  = x_q;
        sinh_d  = y_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef CORDIC_HYP_RANGE_CHK_EN
        rerr_d  = flag_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      step_q  <= '0;
      cosh_q  <= '0;
      sinh_q  <= '0;
      done_q  <= 1'b0;
`ifdef CORDIC_HYP_RANGE_CHK_EN
      flag_q  <= 1'b0;
      rerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      step_q  <= step_d;
      cosh_q  <= cosh_d;
      sinh_q  <= sinh_d;
      done_q  <= done_d;
`ifdef CORDIC_HYP_RANGE_CHK_EN
      flag_q  <= flag_d;
      rerr_q  <= rerr_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cosh_out = cosh_q;
  assign sinh_out = sinh_q;

endmodule

// File: tb/tb_cordic_hyp_core.sv
// Self-checking bench for cordic_hyp_core.
// Table vectors, random vectors vs. arithmetic model, protocol sequences.
module tb_cordic_hyp_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] z_in = '0;
  logic        busy, done, range_err;
  logic [15:0] cosh_out, sinh_out;

  int nchk = 0;
  int nerr = 0;

  cordic_hyp_core #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .z_in(z_in),
    .busy(busy),
    .done(done),
    .cosh_out(cosh_out),
    .sinh_out(sinh_out),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] z;
    int ec;
    int es;
  } vec_t;

  vec_t tbl[3];

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Reference: plain-integer CORDIC over the shift schedule.
  task automatic model(input logic [15:0] zin, output int xc, output int ys,
                       output int err);
    int sched[16] = '{1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14};
    int atab[15]  = '{0,4500,2092,1029,513,256,128,64,32,16,8,4,2,1,1};
    int x, y, z, i, d, nx, ny;
    x = 9892;
    y = 0;
    z = s16(zin);
    err = 0;
`ifdef CORDIC_HYP_RANGE_CHK_EN
    if (z > 9160) begin z = 9160; err = 1; end
    if (z < -9160) begin z = -9160; err = 1; end
`endif
    for (int k = 0; k < 16; k++) begin
      i  = sched[k];
      d  = (z >= 0) ? 1 : -1;
      nx = wrap16(x + d * (y >>> i));
      ny = wrap16(y + d * (x >>> i));
      z  = wrap16(z - d * atab[i]);
      x  = nx;
      y  = ny;
    end
    xc = x;
    ys = y;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp,
                         input int tol);
    nchk++;
    if (act < exp - tol || act > exp + tol) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d+-%0d", nm, act, exp, tol);
    end
  endtask

  // Accept one request and wait for done; lat = edges from accept to done.
  task automatic run(input logic [15:0] z, output int lat);
    @(negedge clk);
    start = 1'b1;
    z_in  = z;
    @(posedge clk);
    #1;
    start = 1'b0;
    z_in  = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string nm, input logic [15:0] z);
    int lat, ec, es, ee;
    run(z, lat);
    model(z, ec, es, ee);
    chk({nm, " latency"}, lat, 17);
    chk({nm, " cosh"}, s16(cosh_out), ec);
    chk({nm, " sinh"}, s16(sinh_out), es);
    chk({nm, " range_err"}, int'(range_err), ee);
    chk({nm, " busy at done"}, int'(busy), 0);
  endtask

  initial begin
    int lat, cnt, first, prev, ec, es, ee;
    logic [15:0] rz;

    tbl[0] = '{z: 16'sd0,     ec: 8192, es: 0};
    tbl[1] = '{z: 16'sd4096,  ec: 9237, es: 4269};
    tbl[2] = '{z: -16'sd4096, ec: 9237, es: -4269};

    // reset with random inputs
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'($urandom);
      z_in  = 16'($urandom);
    end
    #1;
    chk("rst cosh", int'(cosh_out), 0);
    chk("rst sinh", int'(sinh_out), 0);
    chk("rst done", int'(done), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst range_err", int'(range_err), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("idle no done", cnt, 0);
    chk("idle busy", int'(busy), 0);

    // table vectors
    for (int k = 0; k < 3; k++) begin
      run_check($sformatf("tbl%0d", k), tbl[k].z);
      chk_tol($sformatf("tbl%0d cosh tol", k), s16(cosh_out), tbl[k].ec, 4);
      chk_tol($sformatf("tbl%0d sinh tol", k), s16(sinh_out), tbl[k].es, 4);
    end

    // random in-range vectors, back-to-back after done
    for (int k = 0; k < 20; k++) begin
      rz = 16'($urandom_range(18320) - 9160);
      run_check($sformatf("rnd%0d", k), rz);
    end

    // start pulses while busy are ignored
    @(negedge clk);
    start = 1'b1;
    z_in  = 16'd3000;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy after accept", int'(busy), 1);
    cnt = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 9);
      z_in  = 16'($urandom);
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    start = 1'b0;
    model(16'd3000, ec, es, ee);
    chk("ignored start done count", cnt, 1);
    chk("ignored start latency", first, 17);
    chk("ignored start cosh", s16(cosh_out), ec);
    chk("ignored start sinh", s16(sinh_out), es);

    // start held high
    @(negedge clk);
    start = 1'b1;
    z_in  = 16'hF000;
    model(16'hF000, ec, es, ee);
    cnt = 0;
    prev = -1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        chk("held cosh", s16(cosh_out), ec);
        chk("held sinh", s16(sinh_out), es);
        if (prev >= 0)
          chk_tol("held interval", c - prev, 17, 1);
        prev = c;
      end
    end
    @(negedge clk);
    start = 1'b0;
    nchk++;
    if (cnt < 3) begin
      nerr++;
      $display("FAIL held count: got %0d expected >=3", cnt);
    end
    lat = 0;
    while (busy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held drain", int'(busy), 0);
    @(posedge clk);

    // reset during step 8
    @(negedge clk);
    start = 1'b1;
    z_in  = 16'd4096;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst cosh", int'(cosh_out), 0);
    chk("midrst sinh", int'(sinh_out), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("midrst no done", cnt, 0);
    run_check("post reset", 16'd4096);

`ifdef CORDIC_HYP_RANGE_CHK_EN
    begin
      int c1, s1;
      run_check("clamp hi", 16'd16000);
      chk("clamp hi flag", int'(range_err), 1);
      c1 = s16(cosh_out);
      s1 = s16(sinh_out);
      run_check("clamp ref", 16'd9160);
      chk("clamp ref flag", int'(range_err), 0);
      chk("clamp cosh same", c1, s16(cosh_out));
      chk("clamp sinh same", s1, s16(sinh_out));
      run_check("clamp lo", 16'h8000);
      chk("clamp lo flag", int'(range_err), 1);
      run_check("after clamp", 16'd4096);
      chk("after clamp flag", int'(range_err), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
